i2s_xcvr: RTL and testbench
===========================

Name: i2s_xcvr

Overview:
- Parametrised I2S/left-justified master transceiver; the next generation of the pedal's codec interface.
- Generates sclk/lrck from mclk, deserialises stereo ADC data and serialises stereo DAC data.
- Configurable sample width, slot width, clock ratio and frame format.
- Adds a TX ready/valid handshake with a single holding buffer, an underrun flag, and registered, always-defined RX outputs.

Parameters:
- SAMPLE_W, 24, audio sample width per channel; must be ≤ SLOT_W.
- SLOT_W, 32, sclk periods per channel slot; power of two, ≥ 8.
- MCLK_PER_SCLK, 8, mclk cycles per sclk period; power of two, ≥ 4.
- FMT, sample_pkg::FMT_I2S, frame format: FMT_I2S (MSB one sclk after the lrck edge) or FMT_LJ (MSB on the lrck edge).

Ports:
- mclk  in  1  master clock (22.579 MHz nominal).
- rst  in  1  reset, synchronous, active-high.
- rx_lc  out  SAMPLE_W  left sample received.
- rx_rc  out  SAMPLE_W  right sample received.
- rx_vld  out  1  one-cycle pulse; rx_lc/rx_rc updated.
- tx_lc  in  SAMPLE_W  left sample to transmit.
- tx_rc  in  SAMPLE_W  right sample to transmit.
- tx_vld  in  1  tx sample pair offered.
- tx_rdy  out  1  holding buffer empty; transfer occurs on tx_vld & tx_rdy.
- tx_underrun  out  1  one-cycle pulse; frame started with no new tx data.
- lrck  out  1  word select; 0 = left slot.
- sclk  out  1  bit clock.
- sdi  in  1  serial data from ADC.
- sdo  out  1  serial data to DAC.

Behaviour:
- Timing counter:
  - Free-running cnt, width log2(MCLK_PER_SCLK * 2 * SLOT_W); wraps once per frame; reset to 0.
  - D = MCLK_PER_SCLK, H = D/2.
  - sclk = cnt[log2(D)-1]; lrck = cnt MSB; both are direct register bits.
  - Period index p = cnt / D, range 0..2*SLOT_W-1.
  - Format offset OFS = 1 for FMT_I2S, 0 for FMT_LJ.
- Strobes:
  - Fall edge: cnt[log2(D)-1:0] == D-1.
  - Rise edge: cnt[log2(D)-1:0] == H-1.
  - Frame edge: fall edge where the next p == OFS.
- TX:
  - Hold register plus full flag; tx_rdy = ~full.
  - On tx_vld & tx_rdy: capture {tx_lc, tx_rc} and set full.
  - 2*SLOT_W-bit shift register; sdo = its MSB.
  - On frame edge, if full: load {hold_lc, 0 pad to SLOT_W, hold_rc, 0 pad} and clear full.
  - On frame edge, if not full: load all zeros and pulse tx_underrun for 1 cycle.
  - On any other fall edge: shift left by 1, zero fill.
  - Same-cycle frame edge and tx_vld with hold empty: the load uses pre-edge state (zeros, underrun); the new data lands in hold for the next frame.
  - With hold full, tx_vld is ignored (tx_rdy = 0).
- RX:
  - 2*SLOT_W-bit shift register; sdi shifted in LSB-first-arrival on each rise edge.
  - Last bit of a frame is the rise edge in p = (OFS + 2*SLOT_W - 1) mod (2*SLOT_W).
  - On the cycle after that capture: rx_lc = shreg[2*SLOT_W-1 -: SAMPLE_W], rx_rc = shreg[SLOT_W-1 -: SAMPLE_W], rx_vld = 1.
  - Outputs hold their value between updates and are never X.
  - Defaults: rx_vld is high during cnt == 509 (FMT_LJ) or cnt == 5 (FMT_I2S).
- Reset (also mid-frame):
  - cnt, both shift registers, hold, full, rx_lc, rx_rc, rx_vld and tx_underrun are cleared.
  - sclk = lrck = sdo = 0; tx_rdy = 1 in the first cycle after reset.
  - The frame restarts at cnt = 0; pending hold data is discarded.
- First frame after reset with no tx write: the first frame edge pulses tx_underrun and transmits zeros.

Decomposition:
- sample_pkg gains: fmt_e enum {FMT_I2S, FMT_LJ}, SAMPLE_W_DEF = 24, SLOT_W_DEF = 32.
- sample_t is built from SAMPLE_W_DEF.
- One sub-module, i2s_clkgen: owns cnt and outputs sclk, lrck, fall/rise/frame strobes and p, parametrised by MCLK_PER_SCLK, SLOT_W and FMT.

Test Plan:
- Defaults, FMT_LJ, write tx {lc=0xA5A5A5, rc=0x3C3C3C} before frame 0 → sdo reproduces 0xA5A5A5 then 8 zeros in the lrck=0 slot and 0x3C3C3C then 8 zeros in the lrck=1 slot, changing only on sclk falls; sclk period 8 mclk, lrck period 512 mclk.
- Loopback sdo→sdi, FMT_I2S, write {0x800001, 0x7FFFFE} → the frame after transmission gives rx_lc=0x800001, rx_rc=0x7FFFFE with rx_vld pulsed once during cnt==5; exactly 1 rx_vld per 512 cycles.
- Handshake: tx_vld held high continuously → tx_rdy drops after one accept and rises for 1 cycle after each frame edge; no tx_underrun after the first frame.
- No tx writes → tx_underrun pulses once per frame at the frame edge; sdo stays 0.
- tx_vld asserted in the same cycle as the frame edge with hold empty → tx_underrun=1 that cycle; the data appears on sdo in the following frame.
- SAMPLE_W=16, SLOT_W=16, MCLK_PER_SCLK=4 loopback → rx_lc/rx_rc match 0x1234/0xFEDC; lrck period 128 mclk.
- Assert rst mid right slot → next cycle sclk=lrck=sdo=0, tx_rdy=1, rx outputs 0; the first tx_underrun after release occurs at the first frame edge.

Source files
------------

// File: rtl/sample_pkg.sv
// Shared audio types and frame-format helpers for the codec interface.
package sample_pkg;

    typedef enum logic {FMT_I2S, FMT_LJ} fmt_e;

    localparam int SAMPLE_W_DEF = 24;
    localparam int SLOT_W_DEF   = 32;

    typedef logic [SAMPLE_W_DEF-1:0] sample_t;

    typedef struct packed {
        sample_t lc;
        sample_t rc;
    } stereo_t;

    // Period in which the last bit of a frame sits; the frame edge is the fall ending it.
    function automatic int last_period(fmt_e fmt, int slot_w);
        return ((fmt == FMT_I2S ? 1 : 0) + 2 * slot_w - 1) % (2 * slot_w);
    endfunction

endpackage

// File: rtl/i2s_xcvr_if.sv
// Sample handshake and serial pins of the I2S transceiver; master is the transceiver side.
interface i2s_xcvr_if #(
    parameter int SAMPLE_W = sample_pkg::SAMPLE_W_DEF
);
    logic [SAMPLE_W-1:0] rx_lc;
    logic [SAMPLE_W-1:0] rx_rc;
    logic                rx_vld;
    logic [SAMPLE_W-1:0] tx_lc;
    logic [SAMPLE_W-1:0] tx_rc;
    logic                tx_vld;
    logic                tx_rdy;
    logic                tx_underrun;
    logic                lrck;
    logic                sclk;
    logic                sdi;
    logic                sdo;

    modport master (
        output rx_lc, rx_rc, rx_vld, tx_rdy, tx_underrun, lrck, sclk, sdo,
        input  tx_lc, tx_rc, tx_vld, sdi
    );

    modport slave (
        input  rx_lc, rx_rc, rx_vld, tx_rdy, tx_underrun, lrck, sclk, sdo,
        output tx_lc, tx_rc, tx_vld, sdi
    );
endinterface

// File: rtl/i2s_xcvr_clkgen.sv
// Frame timing: free-running counter giving sclk/lrck as register bits plus edge strobes.
// Strobes are decoded one mclk ahead of the sclk/lrck transition they announce; no backpressure.
module i2s_clkgen
    import sample_pkg::*;
#(
    parameter int   MCLK_PER_SCLK = 8,
    parameter int   SLOT_W        = SLOT_W_DEF,
    parameter fmt_e FMT           = FMT_I2S
) (
    input  logic                          mclk,
    input  logic                          rst,
    output logic                          sclk,
    output logic                          lrck,
    output logic                          fall,
    output logic                          rise,
    output logic                          frame,
    output logic [$clog2(2*SLOT_W)-1:0]   p
);
    localparam int DW     = $clog2(MCLK_PER_SCLK);
    localparam int CW     = $clog2(MCLK_PER_SCLK * 2 * SLOT_W);
    localparam int PW     = $clog2(2 * SLOT_W);
    localparam int LAST_P = last_period(FMT, SLOT_W);

    logic [CW-1:0] cnt;

    always_ff @(posedge mclk) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt + CW'(1);
    end

    assign sclk  = cnt[DW-1];
    assign lrck  = cnt[CW-1];
    assign p     = cnt[CW-1:DW];
    assign fall  = (cnt[DW-1:0] == {DW{1'b1}});
    assign rise  = (cnt[DW-1:0] == DW'(MCLK_PER_SCLK / 2 - 1));
    assign frame = fall && (p == PW'(LAST_P));
endmodule

// File: rtl/i2s_xcvr.sv
// I2S / left-justified master: stereo TX via single holding buffer, stereo RX with registered outputs.
// RX pair valid two mclk after the last bit is sampled; tx_rdy low while the hold buffer is full.
module i2s_xcvr
    import sample_pkg::*;
#(
    parameter int   SAMPLE_W      = SAMPLE_W_DEF,
    parameter int   SLOT_W        = SLOT_W_DEF,
    parameter int   MCLK_PER_SCLK = 8,
    parameter fmt_e FMT           = FMT_I2S
) (
    input  logic          mclk,
    input  logic          rst,
    i2s_xcvr_if.master    io
);
    localparam int FW     = 2 * SLOT_W;
    localparam int PW     = $clog2(FW);
    localparam int PAD    = SLOT_W - SAMPLE_W;
    localparam int LAST_P = last_period(FMT, SLOT_W);

    logic          sclk, lrck, fall, rise, frame;
    logic [PW-1:0] p;

    i2s_clkgen #(
        .MCLK_PER_SCLK (MCLK_PER_SCLK),
        .SLOT_W        (SLOT_W),
        .FMT           (FMT)
    ) u_clkgen (
        .mclk  (mclk),
        .rst   (rst),
        .sclk  (sclk),
        .lrck  (lrck),
        .fall  (fall),
        .rise  (rise),
        .frame (frame),
        .p     (p)
    );

    logic [SAMPLE_W-1:0] hold_lc, hold_rc;
    logic                full;
    logic [FW-1:0]       tx_sh;
    logic                underrun;
    logic [FW-1:0]       rx_sh;
    logic                rx_last;
    logic [SAMPLE_W-1:0] rx_lc, rx_rc;
    logic                rx_vld;
    logic [SLOT_W-1:0]   slot_lc, slot_rc;

    // Samples sit MSB-aligned in their slot, zero padded below.
    assign slot_lc = SLOT_W'(hold_lc) << PAD;
    assign slot_rc = SLOT_W'(hold_rc) << PAD;

    always_ff @(posedge mclk) begin
        if (rst) begin
            hold_lc  <= '0;
            hold_rc  <= '0;
            full     <= 1'b0;
            tx_sh    <= '0;
            underrun <= 1'b0;
            rx_sh    <= '0;
            rx_last  <= 1'b0;
            rx_lc    <= '0;
            rx_rc    <= '0;
            rx_vld   <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (frame) begin
                if (full) begin
                    tx_sh <= {slot_lc, slot_rc};
                    full  <= 1'b0;
                end else begin
                    tx_sh    <= '0;
                    underrun <= 1'b1;
                end
            end else if (fall) begin
                tx_sh <= {tx_sh[FW-2:0], 1'b0};
            end
            // Uses pre-edge full: a write coinciding with an empty-hold frame edge waits a frame.
            if (io.tx_vld && !full) begin
                hold_lc <= io.tx_lc;
                hold_rc <= io.tx_rc;
                full    <= 1'b1;
            end

            if (rise) rx_sh <= {rx_sh[FW-2:0], io.sdi};
            rx_last <= rise && (p == PW'(LAST_P));
            rx_vld  <= rx_last;
            if (rx_last) begin
                rx_lc <= rx_sh[FW-1 -: SAMPLE_W];
                rx_rc <= rx_sh[SLOT_W-1 -: SAMPLE_W];
            end
        end
    end

    assign io.sclk        = sclk;
    assign io.lrck        = lrck;
    assign io.sdo         = tx_sh[FW-1];
    assign io.tx_rdy      = ~full;
    assign io.tx_underrun = underrun;
    assign io.rx_lc       = rx_lc;
    assign io.rx_rc       = rx_rc;
    assign io.rx_vld      = rx_vld;
endmodule

// File: tb/tb_i2s_xcvr.sv
// Directed bench: three transceivers (LJ, I2S, small I2S), each with sdo looped back to sdi.
module tb_i2s_xcvr;
    import sample_pkg::*;

    logic mclk = 1'b0;
    logic rst  = 1'b1;
    int   tcnt;
    int   vectors = 0;
    int   errors  = 0;

    always #5 mclk = ~mclk;

    // Reference frame position, restarted by reset exactly like the design's counter.
    always @(posedge mclk) begin
        if (rst) tcnt <= 0;
        else     tcnt <= tcnt + 1;
    end

    i2s_xcvr_if #(.SAMPLE_W(24)) if_lj ();
    i2s_xcvr_if #(.SAMPLE_W(24)) if_i2s ();
    i2s_xcvr_if #(.SAMPLE_W(16)) if_s ();

    assign if_lj.sdi  = if_lj.sdo;
    assign if_i2s.sdi = if_i2s.sdo;
    assign if_s.sdi   = if_s.sdo;

    i2s_xcvr #(.FMT(FMT_LJ)) u_lj (.mclk(mclk), .rst(rst), .io(if_lj));
    i2s_xcvr #(.FMT(FMT_I2S)) u_i2s (.mclk(mclk), .rst(rst), .io(if_i2s));
    i2s_xcvr #(.SAMPLE_W(16), .SLOT_W(16), .MCLK_PER_SCLK(4), .FMT(FMT_I2S))
        u_s (.mclk(mclk), .rst(rst), .io(if_s));

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic run_to(input int t);
        while (tcnt < t) step();
    endtask

    task automatic do_reset();
        if_lj.tx_vld = 1'b0; if_i2s.tx_vld = 1'b0; if_s.tx_vld = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({if_lj.sclk, if_lj.lrck, if_lj.sdo, if_lj.tx_rdy, if_lj.rx_vld, if_lj.tx_underrun} !== 6'b000100) begin
            errors++; $display("FAIL reset_lj_ctl: got %b want 000100",
                {if_lj.sclk, if_lj.lrck, if_lj.sdo, if_lj.tx_rdy, if_lj.rx_vld, if_lj.tx_underrun});
        end
        vectors++;
        if ({if_lj.rx_lc, if_lj.rx_rc} !== 48'h0) begin
            errors++; $display("FAIL reset_lj_rx: got %h want 0", {if_lj.rx_lc, if_lj.rx_rc});
        end
        vectors++;
        if ({if_i2s.sclk, if_i2s.lrck, if_i2s.sdo, if_i2s.tx_rdy, if_i2s.rx_vld, if_i2s.tx_underrun} !== 6'b000100) begin
            errors++; $display("FAIL reset_i2s_ctl: got %b want 000100",
                {if_i2s.sclk, if_i2s.lrck, if_i2s.sdo, if_i2s.tx_rdy, if_i2s.rx_vld, if_i2s.tx_underrun});
        end
        vectors++;
        if ({if_s.sclk, if_s.lrck, if_s.sdo, if_s.tx_rdy, if_s.rx_vld, if_s.tx_underrun} !== 6'b000100) begin
            errors++; $display("FAIL reset_s_ctl: got %b want 000100",
                {if_s.sclk, if_s.lrck, if_s.sdo, if_s.tx_rdy, if_s.rx_vld, if_s.tx_underrun});
        end
        vectors++;
        if ({if_s.rx_lc, if_s.rx_rc} !== 32'h0) begin
            errors++; $display("FAIL reset_s_rx: got %h want 0", {if_s.rx_lc, if_s.rx_rc});
        end
    endtask

    task automatic test_lj_tx();
        logic [63:0] exp;
        int bad_sdo, bad_clk, n_und;
        logic [47:0] rx_snap;
        logic        vld_snap;
        do_reset();
        exp = {24'hA5A5A5, 8'h00, 24'h3C3C3C, 8'h00};
        bad_sdo = 0; bad_clk = 0; n_und = 0; rx_snap = '0; vld_snap = 1'b0;
        if_lj.tx_lc = 24'hA5A5A5; if_lj.tx_rc = 24'h3C3C3C; if_lj.tx_vld = 1'b1;
        vectors++;
        if (if_lj.tx_rdy !== 1'b1) begin errors++; $display("FAIL lj_rdy_empty: got %b want 1", if_lj.tx_rdy); end
        step();
        if_lj.tx_vld = 1'b0;
        vectors++;
        if (if_lj.tx_rdy !== 1'b0) begin errors++; $display("FAIL lj_rdy_full: got %b want 0", if_lj.tx_rdy); end
        run_to(512);
        while (tcnt < 1024) begin
            if (if_lj.sdo !== exp[63 - (tcnt % 512) / 8]) bad_sdo++;
            if (if_lj.sclk !== ((tcnt % 8) >= 4)) bad_clk++;
            if (if_lj.lrck !== ((tcnt % 512) >= 256)) bad_clk++;
            if (if_lj.tx_underrun !== 1'b0) n_und++;
            if (tcnt == 1021) begin rx_snap = {if_lj.rx_lc, if_lj.rx_rc}; vld_snap = if_lj.rx_vld; end
            step();
        end
        vectors++;
        if (bad_sdo !== 0) begin errors++; $display("FAIL lj_sdo_frame: %0d bad cycles, want 0", bad_sdo); end
        vectors++;
        if (bad_clk !== 0) begin errors++; $display("FAIL lj_sclk_lrck: %0d bad cycles, want 0", bad_clk); end
        vectors++;
        if (n_und !== 0) begin errors++; $display("FAIL lj_no_underrun: %0d pulses, want 0", n_und); end
        vectors++;
        if ({vld_snap, rx_snap} !== {1'b1, 24'hA5A5A5, 24'h3C3C3C}) begin
            errors++; $display("FAIL lj_rx_loop: got vld=%b %h want vld=1 a5a5a53c3c3c", vld_snap, rx_snap);
        end
    endtask

    task automatic test_underrun();
        int n_und, bad_pos, n_sdo, n_rdy;
        do_reset();
        n_und = 0; bad_pos = 0; n_sdo = 0; n_rdy = 0;
        while (tcnt < 1100) begin
            if (if_i2s.tx_underrun === 1'b1) begin
                n_und++;
                if (tcnt % 512 != 8) bad_pos++;
            end
            if (if_i2s.sdo !== 1'b0) n_sdo++;
            if (if_i2s.tx_rdy !== 1'b1) n_rdy++;
            step();
        end
        vectors++;
        if (n_und !== 3) begin errors++; $display("FAIL und_count: got %0d want 3", n_und); end
        vectors++;
        if (bad_pos !== 0) begin errors++; $display("FAIL und_position: %0d off-edge pulses, want 0", bad_pos); end
        vectors++;
        if (n_sdo !== 0) begin errors++; $display("FAIL und_sdo_zero: %0d high cycles, want 0", n_sdo); end
        vectors++;
        if (n_rdy !== 0) begin errors++; $display("FAIL und_rdy_high: %0d low cycles, want 0", n_rdy); end
    endtask

    task automatic test_loopback();
        int n_vld, bad_pos;
        logic [47:0] snap;
        do_reset();
        n_vld = 0; bad_pos = 0; snap = '0;
        if_i2s.tx_lc = 24'h800001; if_i2s.tx_rc = 24'h7FFFFE; if_i2s.tx_vld = 1'b1;
        vectors++;
        if (if_i2s.tx_rdy !== 1'b1) begin errors++; $display("FAIL i2s_rdy_empty: got %b want 1", if_i2s.tx_rdy); end
        step();
        if_i2s.tx_vld = 1'b0;
        while (tcnt < 1100) begin
            if (if_i2s.rx_vld === 1'b1) begin
                n_vld++;
                if (tcnt % 512 != 5) bad_pos++;
            end
            if (tcnt == 517) snap = {if_i2s.rx_lc, if_i2s.rx_rc};
            step();
        end
        vectors++;
        if (snap !== {24'h800001, 24'h7FFFFE}) begin
            errors++; $display("FAIL i2s_rx_data: got %h want 8000017ffffe", snap);
        end
        vectors++;
        if (n_vld !== 3) begin errors++; $display("FAIL i2s_rx_vld_count: got %0d want 3", n_vld); end
        vectors++;
        if (bad_pos !== 0) begin errors++; $display("FAIL i2s_rx_vld_pos: %0d off-position pulses, want 0", bad_pos); end
    endtask

    task automatic test_handshake();
        int bad_rdy, n_und;
        do_reset();
        bad_rdy = 0; n_und = 0;
        if_lj.tx_lc = 24'h0F0F0F; if_lj.tx_rc = 24'hF0F0F0; if_lj.tx_vld = 1'b1;
        while (tcnt < 1100) begin
            if (if_lj.tx_rdy !== ((tcnt % 512) == 0)) bad_rdy++;
            if (if_lj.tx_underrun !== 1'b0) n_und++;
            step();
        end
        if_lj.tx_vld = 1'b0;
        vectors++;
        if (bad_rdy !== 0) begin errors++; $display("FAIL hs_rdy_pattern: %0d bad cycles, want 0", bad_rdy); end
        vectors++;
        if (n_und !== 0) begin errors++; $display("FAIL hs_no_underrun: %0d pulses, want 0", n_und); end
    endtask

    task automatic test_same_cycle();
        logic [63:0] exp;
        int bad_sdo, n_und;
        logic [48:0] snap;
        do_reset();
        exp = {24'h123456, 8'h00, 24'h654321, 8'h00};
        bad_sdo = 0; n_und = 0; snap = '0;
        run_to(511);
        if_lj.tx_lc = 24'h123456; if_lj.tx_rc = 24'h654321; if_lj.tx_vld = 1'b1;
        vectors++;
        if (if_lj.tx_rdy !== 1'b1) begin errors++; $display("FAIL sc_rdy_edge: got %b want 1", if_lj.tx_rdy); end
        step();
        if_lj.tx_vld = 1'b0;
        vectors++;
        if ({if_lj.tx_underrun, if_lj.tx_rdy} !== 2'b10) begin
            errors++; $display("FAIL sc_underrun_rdy: got %b want 10", {if_lj.tx_underrun, if_lj.tx_rdy});
        end
        step();
        while (tcnt < 1536) begin
            if (tcnt < 1024) begin
                if (if_lj.sdo !== 1'b0) bad_sdo++;
            end else begin
                if (if_lj.sdo !== exp[63 - (tcnt % 512) / 8]) bad_sdo++;
            end
            if (if_lj.tx_underrun !== 1'b0) n_und++;
            if (tcnt == 1533) snap = {if_lj.rx_vld, if_lj.rx_lc, if_lj.rx_rc};
            step();
        end
        vectors++;
        if (bad_sdo !== 0) begin errors++; $display("FAIL sc_sdo_next_frame: %0d bad cycles, want 0", bad_sdo); end
        vectors++;
        if (n_und !== 0) begin errors++; $display("FAIL sc_no_second_underrun: %0d pulses, want 0", n_und); end
        vectors++;
        if (snap !== {1'b1, 24'h123456, 24'h654321}) begin
            errors++; $display("FAIL sc_rx_loop: got %h want 1123456654321", snap);
        end
    endtask

    task automatic test_small();
        int bad_clk, n_vld;
        logic [32:0] snap;
        do_reset();
        bad_clk = 0; n_vld = 0; snap = '0;
        if_s.tx_lc = 16'h1234; if_s.tx_rc = 16'hFEDC; if_s.tx_vld = 1'b1;
        vectors++;
        if (if_s.tx_rdy !== 1'b1) begin errors++; $display("FAIL s_rdy_empty: got %b want 1", if_s.tx_rdy); end
        step();
        if_s.tx_vld = 1'b0;
        while (tcnt < 300) begin
            if (if_s.sclk !== ((tcnt % 4) >= 2)) bad_clk++;
            if (if_s.lrck !== ((tcnt % 128) >= 64)) bad_clk++;
            if (if_s.rx_vld === 1'b1) n_vld++;
            if (tcnt == 131) snap = {if_s.rx_vld, if_s.rx_lc, if_s.rx_rc};
            step();
        end
        vectors++;
        if (snap !== {1'b1, 16'h1234, 16'hFEDC}) begin
            errors++; $display("FAIL s_rx_data: got %h want 11234fedc", snap);
        end
        vectors++;
        if (bad_clk !== 0) begin errors++; $display("FAIL s_sclk_lrck: %0d bad cycles, want 0", bad_clk); end
        vectors++;
        if (n_vld !== 3) begin errors++; $display("FAIL s_rx_vld_count: got %0d want 3", n_vld); end
    endtask

    task automatic test_reset_mid();
        int n_und, bad_pos, n_sdo;
        do_reset();
        n_und = 0; bad_pos = 0; n_sdo = 0;
        if_lj.tx_lc = 24'hA5A5A5; if_lj.tx_rc = 24'h3C3C3C; if_lj.tx_vld = 1'b1;
        step();
        if_lj.tx_vld = 1'b0;
        run_to(600);
        if_lj.tx_lc = 24'h5A5A5A; if_lj.tx_rc = 24'hFFFFFF; if_lj.tx_vld = 1'b1;
        step();
        if_lj.tx_vld = 1'b0;
        run_to(1100);
        if_lj.tx_lc = 24'h111111; if_lj.tx_rc = 24'h222222; if_lj.tx_vld = 1'b1;
        step();
        if_lj.tx_vld = 1'b0;
        run_to(1300);
        vectors++;
        if ({if_lj.lrck, if_lj.sdo, if_lj.tx_rdy, if_lj.rx_lc} !== {3'b110, 24'hA5A5A5}) begin
            errors++; $display("FAIL mid_pre_state: got %h want 6a5a5a5",
                {1'b0, if_lj.lrck, if_lj.sdo, if_lj.tx_rdy, if_lj.rx_lc});
        end
        rst = 1'b1;
        step();
        vectors++;
        if ({if_lj.sclk, if_lj.lrck, if_lj.sdo, if_lj.tx_rdy, if_lj.rx_vld, if_lj.tx_underrun} !== 6'b000100) begin
            errors++; $display("FAIL mid_rst_ctl: got %b want 000100",
                {if_lj.sclk, if_lj.lrck, if_lj.sdo, if_lj.tx_rdy, if_lj.rx_vld, if_lj.tx_underrun});
        end
        vectors++;
        if ({if_lj.rx_lc, if_lj.rx_rc} !== 48'h0) begin
            errors++; $display("FAIL mid_rst_rx: got %h want 0", {if_lj.rx_lc, if_lj.rx_rc});
        end
        rst = 1'b0;
        while (tcnt < 1024) begin
            if (if_lj.tx_underrun === 1'b1) begin
                n_und++;
                if (tcnt != 512) bad_pos++;
            end
            if (if_lj.sdo !== 1'b0) n_sdo++;
            step();
        end
        vectors++;
        if ({n_und, bad_pos} !== {32'd1, 32'd0}) begin
            errors++; $display("FAIL mid_first_underrun: got %0d pulses (%0d misplaced) want 1 at cnt 512", n_und, bad_pos);
        end
        vectors++;
        if (n_sdo !== 0) begin errors++; $display("FAIL mid_hold_discarded: %0d sdo high cycles, want 0", n_sdo); end
    endtask

    initial begin
        if_lj.tx_vld = 1'b0;  if_lj.tx_lc = '0;  if_lj.tx_rc = '0;
        if_i2s.tx_vld = 1'b0; if_i2s.tx_lc = '0; if_i2s.tx_rc = '0;
        if_s.tx_vld = 1'b0;   if_s.tx_lc = '0;   if_s.tx_rc = '0;
        test_reset();
        test_lj_tx();
        test_underrun();
        test_loopback();
        test_handshake();
        test_same_cycle();
        test_small();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
